// File: rtl/xif_result_buffer_pkg.sv
// Shared CV-X-IF types for the result buffer.
//   X_ID_WIDTH  : offload instruction ID width
//   x_commit_t  : commit channel payload {id, commit_kill}
//   x_result_t  : result channel payload
//   rb_entry_t  : one in-flight slot of the result buffer
package xif_result_buffer_pkg;

   localparam int X_ID_WIDTH = 4;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0] id;
      logic                  commit_kill;
   } x_commit_t;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0] id;
      logic [31:0]           data;
      logic [4:0]            rd;
      logic                  we;
      logic [5:0]            ecsdata;
      logic [2:0]            ecswe;
      logic                  exc;
      logic [5:0]            exccode;
      logic                  err;
      logic                  dbg;
   } x_result_t;

   typedef struct packed {
      logic                  valid;
      logic [X_ID_WIDTH-1:0] id;
      logic [4:0]            rd;
      logic                  writeback;
      logic                  committed;
      logic                  killed;
      logic                  has_result;
      logic [31:0]           data;
      logic                  exc;
      logic [5:0]            exccode;
   } rb_entry_t;

endpackage

// File: rtl/xif_id_match.sv
// Parallel ID lookup over all buffer slots.
//   entry_valid_i / entry_id_i : slot occupancy and stored IDs
//   commit_* / exec_*          : lookup strobes and IDs
//   commit_hit_o / exec_hit_o  : per-slot match vectors (one-hot while IDs
//                                in flight are unique)
module xif_id_match #(
   parameter int DEPTH = 4,
   parameter int ID_W  = 4
) (
   input  logic [DEPTH-1:0]           entry_valid_i,
   input  logic [DEPTH-1:0][ID_W-1:0] entry_id_i,
   input  logic                       commit_valid_i,
   input  logic [ID_W-1:0]            commit_id_i,
   input  logic                       exec_valid_i,
   input  logic [ID_W-1:0]            exec_id_i,
   output logic [DEPTH-1:0]           commit_hit_o,
   output logic [DEPTH-1:0]           exec_hit_o
);

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      assign commit_hit_o[g] = commit_valid_i && entry_valid_i[g] &&
                               (entry_id_i[g] == commit_id_i);
      assign exec_hit_o[g]   = exec_valid_i && entry_valid_i[g] &&
                               (entry_id_i[g] == exec_id_i);
   end

endmodule

// File: rtl/xif_result_buffer.sv
// In-order result buffer for a CV-X-IF coprocessor.
// Accepted issues take a slot at the tail; commit and execution results
// are matched by ID in any order; results leave from the head strictly in
// issue order. Killed entries retire silently once their result arrives.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   issue_*               : issue channel observation (allocation)
//   commit_valid_i/commit_i : commit / kill by ID
//   exec_*                : execution unit write-back (always accepted)
//   result_valid_o/ready_i/result_o : result channel to the core
module xif_result_buffer
   import xif_result_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ID_W  = X_ID_WIDTH
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            issue_valid_i,
   output logic            issue_ready_o,
   input  logic [ID_W-1:0] issue_id_i,
   input  logic            issue_accept_i,
   input  logic            issue_writeback_i,
   input  logic [4:0]      issue_rd_i,
   input  logic            commit_valid_i,
   input  x_commit_t       commit_i,
   input  logic            exec_valid_i,
   input  logic [ID_W-1:0] exec_id_i,
   input  logic [31:0]     exec_data_i,
   input  logic            exec_exc_i,
   input  logic [5:0]      exec_exccode_i,
   output logic            result_valid_o,
   input  logic            result_ready_i,
   output x_result_t       result_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   rb_entry_t                  ent [DEPTH];
   logic [PTR_W-1:0]           head, tail;
   logic [CNT_W-1:0]           occ;

   logic [DEPTH-1:0]           ent_valid;
   logic [DEPTH-1:0][ID_W-1:0] ent_id;
   logic [DEPTH-1:0]           commit_hit, exec_hit;
   logic [ID_W-1:0]            commit_id;

   rb_entry_t                  head_ent, new_ent;
   logic                       head_live, head_drop, retire, alloc;
   logic                       alloc_commit, alloc_exec;

   assign commit_id = ID_W'(commit_i.id);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_valid[i] = ent[i].valid;
         ent_id[i]    = ID_W'(ent[i].id);
      end
   end

   xif_id_match #(.DEPTH(DEPTH), .ID_W(ID_W)) u_match (
      .entry_valid_i  (ent_valid),
      .entry_id_i     (ent_id),
      .commit_valid_i (commit_valid_i),
      .commit_id_i    (commit_id),
      .exec_valid_i   (exec_valid_i),
      .exec_id_i      (exec_id_i),
      .commit_hit_o   (commit_hit),
      .exec_hit_o     (exec_hit)
   );

   assign head_ent  = ent[head];
   assign head_live = head_ent.valid && head_ent.committed &&
                      !head_ent.killed && head_ent.has_result;
   assign head_drop = head_ent.valid && head_ent.killed && head_ent.has_result;
   assign retire    = (head_live && result_ready_i) || head_drop;

   // Reset masks the outputs immediately so nothing stale is presented
   // while the registers are being cleared.
   assign result_valid_o = head_live && !rst_i;
   assign issue_ready_o  = rst_i || (occ != CNT_W'(DEPTH));
   assign alloc          = issue_valid_i && issue_ready_o && issue_accept_i;

   // Commit / exec arriving in the same cycle as the allocation of their ID
   // land directly in the new slot.
   assign alloc_commit = commit_valid_i && (commit_id == issue_id_i);
   assign alloc_exec   = exec_valid_i && (exec_id_i == issue_id_i);

   always_comb begin
      new_ent            = '0;
      new_ent.valid      = 1'b1;
      new_ent.id         = X_ID_WIDTH'(issue_id_i);
      new_ent.rd         = issue_rd_i;
      new_ent.writeback  = issue_writeback_i;
      new_ent.committed  = alloc_commit && !commit_i.commit_kill;
      new_ent.killed     = alloc_commit && commit_i.commit_kill;
      new_ent.has_result = alloc_exec;
      if (alloc_exec) begin
         new_ent.data    = exec_data_i;
         new_ent.exc     = exec_exc_i;
         new_ent.exccode = exec_exccode_i;
      end
   end

   always_comb begin
      result_o = '0;
      if (result_valid_o) begin
         result_o.id      = head_ent.id;
         result_o.data    = head_ent.data;
         result_o.rd      = head_ent.rd;
         result_o.we      = head_ent.writeback && !head_ent.exc;
         result_o.exc     = head_ent.exc;
         result_o.exccode = head_ent.exccode;
      end
   end

   // Only the first commit and the first result for a slot are taken; a
   // repeat cannot disturb a result already being presented.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (exec_hit[i] && !ent[i].has_result) begin
               ent[i].has_result <= 1'b1;
               ent[i].data       <= exec_data_i;
               ent[i].exc        <= exec_exc_i;
               ent[i].exccode    <= exec_exccode_i;
            end
            if (commit_hit[i] && !ent[i].committed && !ent[i].killed) begin
               if (commit_i.commit_kill) ent[i].killed    <= 1'b1;
               else                      ent[i].committed <= 1'b1;
            end
         end
         if (retire) begin
            ent[head].valid <= 1'b0;
            head            <= head + PTR_W'(1);
         end
         // Tail never equals a live head here: allocation is blocked when full.
         if (alloc) begin
            ent[tail] <= new_ent;
            tail      <= tail + PTR_W'(1);
         end
         case ({alloc, retire})
            2'b10:   occ <= occ + CNT_W'(1);
            2'b01:   occ <= occ - CNT_W'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: tb/tb_xif_result_buffer.sv
module tb_xif_result_buffer;
   import xif_result_buffer_pkg::*;

   localparam int DEPTH = 4;
   localparam int ID_W  = X_ID_WIDTH;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            issue_valid_i, issue_ready_o, issue_accept_i, issue_writeback_i;
   logic [ID_W-1:0] issue_id_i;
   logic [4:0]      issue_rd_i;
   logic            commit_valid_i;
   x_commit_t       commit_i;
   logic            exec_valid_i, exec_exc_i;
   logic [ID_W-1:0] exec_id_i;
   logic [31:0]     exec_data_i;
   logic [5:0]      exec_exccode_i;
   logic            result_valid_o, result_ready_i;
   x_result_t       result_o;

   always #5 clk_i = ~clk_i;

   xif_result_buffer #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .issue_valid_i     (issue_valid_i),
      .issue_ready_o     (issue_ready_o),
      .issue_id_i        (issue_id_i),
      .issue_accept_i    (issue_accept_i),
      .issue_writeback_i (issue_writeback_i),
      .issue_rd_i        (issue_rd_i),
      .commit_valid_i    (commit_valid_i),
      .commit_i          (commit_i),
      .exec_valid_i      (exec_valid_i),
      .exec_id_i         (exec_id_i),
      .exec_data_i       (exec_data_i),
      .exec_exc_i        (exec_exc_i),
      .exec_exccode_i    (exec_exccode_i),
      .result_valid_o    (result_valid_o),
      .result_ready_i    (result_ready_i),
      .result_o          (result_o)
   );

   // Reference: in-order list of in-flight instructions.
   typedef struct {
      logic [3:0]  id;
      logic [4:0]  rd;
      bit          wb, cm, kl, hr;
      logic [31:0] data;
      bit          exc;
      logic [5:0]  ec;
   } m_t;

   m_t q[$];
   int n_err = 0;
   int n_chk = 0;
   x_result_t snap;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_chk++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, want);
      end
   endtask

   task automatic idle();
      issue_valid_i = 0; issue_accept_i = 0; issue_writeback_i = 0;
      issue_id_i = '0; issue_rd_i = '0;
      commit_valid_i = 0; commit_i = '0;
      exec_valid_i = 0; exec_id_i = '0; exec_data_i = '0;
      exec_exc_i = 0; exec_exccode_i = '0;
   endtask

   task automatic iss(input logic [3:0] id, input bit wb);
      issue_valid_i = 1; issue_accept_i = 1; issue_id_i = id;
      issue_writeback_i = wb; issue_rd_i = 5'($urandom);
   endtask

   task automatic cmt(input logic [3:0] id, input bit kill);
      commit_valid_i = 1; commit_i.id = id; commit_i.commit_kill = kill;
   endtask

   task automatic exe(input logic [3:0] id, input logic [31:0] d, input bit exc,
                      input logic [5:0] ec);
      exec_valid_i = 1; exec_id_i = id; exec_data_i = d;
      exec_exc_i = exc; exec_exccode_i = ec;
   endtask

   // Apply one clock edge's worth of rules to the reference list.
   task automatic model_update();
      bit ret;
      int sz;
      m_t n;
      if (rst_i) begin
         q.delete();
         return;
      end
      sz  = q.size();
      ret = 0;
      if (sz > 0 && q[0].hr && q[0].kl) ret = 1;
      else if (sz > 0 && q[0].hr && q[0].cm && result_ready_i) ret = 1;
      foreach (q[i]) begin
         if (commit_valid_i && q[i].id == commit_i.id && !q[i].cm && !q[i].kl) begin
            if (commit_i.commit_kill) q[i].kl = 1;
            else                      q[i].cm = 1;
         end
         if (exec_valid_i && q[i].id == exec_id_i && !q[i].hr) begin
            q[i].hr = 1; q[i].data = exec_data_i;
            q[i].exc = exec_exc_i; q[i].ec = exec_exccode_i;
         end
      end
      if (ret) void'(q.pop_front());
      if (issue_valid_i && issue_accept_i && sz < DEPTH) begin
         n.id = issue_id_i; n.rd = issue_rd_i; n.wb = issue_writeback_i;
         n.cm = commit_valid_i && commit_i.id == issue_id_i && !commit_i.commit_kill;
         n.kl = commit_valid_i && commit_i.id == issue_id_i && commit_i.commit_kill;
         n.hr = exec_valid_i && exec_id_i == issue_id_i;
         n.data = n.hr ? exec_data_i : 32'h0;
         n.exc  = n.hr ? exec_exc_i : 1'b0;
         n.ec   = n.hr ? exec_exccode_i : 6'h0;
         q.push_back(n);
      end
   endtask

   // Check outputs mid-cycle, then advance one clock and idle the strobes.
   task automatic cyc();
      x_result_t er;
      logic ev, erdy;
      @(negedge clk_i);
      ev   = !rst_i && q.size() > 0 && q[0].cm && !q[0].kl && q[0].hr;
      erdy = rst_i || (q.size() < DEPTH);
      er   = '0;
      if (ev) begin
         er.id = q[0].id; er.data = q[0].data; er.rd = q[0].rd;
         er.we = q[0].wb && !q[0].exc; er.exc = q[0].exc; er.exccode = q[0].ec;
      end
      chk("result_valid", 64'(result_valid_o), 64'(ev));
      chk("issue_ready", 64'(issue_ready_o), 64'(erdy));
      chk("result", 64'(result_o), 64'(er));
      @(posedge clk_i);
      model_update();
      #1;
      idle();
   endtask

   function automatic logic [3:0] free_id();
      logic [3:0] id;
      bit clash;
      for (int t = 0; t < 64; t++) begin
         id = 4'($urandom);
         clash = 0;
         foreach (q[i]) if (q[i].id == id) clash = 1;
         if (!clash) return id;
      end
      return 4'hf;
   endfunction

   function automatic logic [3:0] pick_id();
      int r;
      r = $urandom_range(0, 9);
      if (q.size() > 0 && r < 7) return q[$urandom_range(0, q.size() - 1)].id;
      if (r < 9) return issue_id_i;
      return 4'($urandom);
   endfunction

   initial begin
      rst_i = 1; result_ready_i = 1; idle();
      cyc(); cyc();
      rst_i = 0;

      // single result end to end
      iss(3, 1); cyc();
      cmt(3, 0); cyc();
      exe(3, 32'hDEADBEEF, 0, 0); cyc();
      chk("r034_valid", 64'(result_valid_o), 64'd1);
      chk("r034_id", 64'(result_o.id), 64'd3);
      chk("r034_data", 64'(result_o.data), 64'hDEADBEEF);
      chk("r034_we", 64'(result_o.we), 64'd1);
      cyc();
      chk("r034_done", 64'(result_valid_o), 64'd0);

      // out-of-order completion, in-order results
      iss(1, 1); cyc();
      iss(2, 1); cyc();
      exe(2, 32'h2222, 0, 0); cyc();
      exe(1, 32'h1111, 0, 0); cyc();
      cmt(1, 0); cyc();
      chk("r035_first", 64'(result_o.id), 64'd1);
      cmt(2, 0); cyc();
      chk("r035_second_v", 64'(result_valid_o), 64'd1);
      chk("r035_second", 64'(result_o.id), 64'd2);
      cyc();

      // full / not full
      for (int i = 1; i <= 4; i++) begin iss(4'(i), 1); cyc(); end
      chk("r036_full", 64'(issue_ready_o), 64'd0);
      cmt(1, 0); exe(1, 32'h55, 0, 0); cyc();
      chk("r036_still_full", 64'(issue_ready_o), 64'd0);
      cyc();
      chk("r036_freed", 64'(issue_ready_o), 64'd1);
      rst_i = 1; cyc(); rst_i = 0;

      // killed entry retires silently and frees its slot
      iss(5, 1); cyc();
      cmt(5, 1); cyc();
      exe(5, 32'h5555, 0, 0); cyc();
      chk("r037_silent", 64'(result_valid_o), 64'd0);
      cyc();
      chk("r037_silent2", 64'(result_valid_o), 64'd0);
      for (int i = 10; i <= 12; i++) begin iss(4'(i), 0); cyc(); end
      chk("r037_three", 64'(issue_ready_o), 64'd1);
      iss(13, 0); cyc();
      chk("r037_four", 64'(issue_ready_o), 64'd0);
      rst_i = 1; cyc(); rst_i = 0;

      // back-pressure with exception result
      result_ready_i = 0;
      iss(9, 1); cyc();
      cmt(9, 0); cyc();
      exe(9, 32'h0BAD_F00D, 1, 6'h2a); cyc();
      chk("r038_valid", 64'(result_valid_o), 64'd1);
      chk("r038_we", 64'(result_o.we), 64'd0);
      chk("r038_exc", 64'(result_o.exc), 64'd1);
      chk("r038_exccode", 64'(result_o.exccode), 64'h2a);
      snap = result_o;
      repeat (5) begin
         cyc();
         chk("r038_stable", 64'(result_o), 64'(snap));
      end
      result_ready_i = 1; cyc();
      chk("r038_gone", 64'(result_valid_o), 64'd0);

      // same-cycle issue/commit/exec, then reset while valid
      result_ready_i = 0;
      iss(7, 1); cmt(7, 0); exe(7, 32'h7777_0007, 0, 0); cyc();
      chk("r039_valid", 64'(result_valid_o), 64'd1);
      chk("r039_id", 64'(result_o.id), 64'd7);
      rst_i = 1; cyc();
      chk("r039_rst", 64'(result_valid_o), 64'd0);
      rst_i = 0; result_ready_i = 1;

      // randomized traffic against the reference list
      for (int c = 0; c < 3000; c++) begin
         rst_i = (c == 1500 || c == 1501);
         if ($urandom_range(0, 1) == 1) begin
            iss(free_id(), 1'($urandom));
            issue_accept_i = ($urandom_range(0, 3) != 0);
         end else begin
            issue_id_i = 4'($urandom);
         end
         if ($urandom_range(0, 1) == 1) cmt(pick_id(), $urandom_range(0, 4) == 0);
         if ($urandom_range(0, 1) == 1)
            exe(pick_id(), $urandom, $urandom_range(0, 5) == 0, 6'($urandom));
         result_ready_i = ($urandom_range(0, 2) != 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/xif_result_buffer.md
XIF_RESULT_BUFFER -- requirements
Module: xif_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of in-flight entries (power of two, 2..16).
REQ-002 SHALL have parameter ID_W, default X_ID_WIDTH (4), offload ID width.
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 issue_valid_i  in  1  core offers an instruction on the issue channel.
REQ-006 issue_ready_o  out  1  buffer can record a new accepted ID.
REQ-007 issue_id_i  in  ID_W  ID of the offered instruction.
REQ-008 issue_accept_i  in  1  coprocessor decoder accepts the instruction.
REQ-009 issue_writeback_i  in  1  accepted instruction writes rd.
REQ-010 issue_rd_i  in  5  destination register.
REQ-011 commit_valid_i  in  1  commit handshake strobe.
REQ-012 commit_i  in  x_commit_t  {id, commit_kill}.
REQ-013 exec_valid_i  in  1  execution unit delivers a result; always accepted.
REQ-014 exec_id_i  in  ID_W; exec_data_i  in  32; exec_exc_i  in  1; exec_exccode_i  in  6.
REQ-015 result_valid_o  out  1; result_ready_i  in  1; result_o  out  x_result_t.

Function
REQ-016 Entries SHALL be allocated in issue order in a circular buffer (head/tail pointers, occupancy counter 0..DEPTH).
REQ-017 Allocation SHALL occur when issue_valid_i && issue_ready_o && issue_accept_i; rejected offers allocate nothing.
REQ-018 issue_ready_o SHALL be 0 when occupancy == DEPTH, else 1; it does not depend on issue_valid_i.
REQ-019 Per entry state: id, rd, writeback, committed, killed, has_result, data, exc, exccode.
REQ-020 Commit SHALL match all valid entries and the same-cycle allocation by ID; kill=0 sets committed, kill=1 sets killed.
REQ-021 exec_valid_i SHALL store data/exc/exccode into the entry with matching ID and set has_result; same-cycle allocation with same ID SHALL also match.
REQ-022 exec or commit with an ID matching no entry SHALL be ignored.
REQ-023 Head live (committed && !killed && has_result) SHALL drive result_valid_o=1 combinationally from registers; first valid is the cycle after the last of commit/exec.
REQ-024 Head killed && has_result SHALL retire silently in one cycle, result_valid_o=0.
REQ-025 result_o: id, data, rd from entry; we = writeback && !exc; exc, exccode from entry; ecsdata, ecswe, err, dbg = 0.
REQ-026 Once result_valid_o=1, result_o SHALL stay stable until result_ready_i=1.
REQ-027 Head retires on result_valid_o && result_ready_i; pointers wrap modulo DEPTH.
REQ-028 Simultaneous allocate and retire at full SHALL NOT occur (issue_ready_o=0); at other occupancies count is unchanged.
REQ-029 Non-head completed entries SHALL wait; results leave strictly in issue order.

Reset
REQ-030 While rst_i=1: occupancy 0, pointers 0, all entry flags 0, result_valid_o=0, issue_ready_o=1, result_o=0.
REQ-031 Reset mid-operation SHALL discard all entries; a pending result_valid_o drops next cycle regardless of result_ready_i.

Structure
REQ-032 x_commit_t, x_result_t, X_ID_WIDTH come from the shared CV-X-IF package; entry struct type defined there too.
REQ-033 One sub-module, xif_id_match, SHALL produce one-hot ID match vectors for commit and exec lookups.

Verification
REQ-034 Issue id 3 accept, commit id 3 kill=0, exec id 3 data 0xDEADBEEF, ready=1 -> one result {id 3, data 0xDEADBEEF, we 1} next cycle.
REQ-035 Issue ids 1,2; exec 2 then 1; commit both -> results id 1 then id 2.
REQ-036 Issue 4 accepted ids with no commits -> issue_ready_o=0; retire one -> issue_ready_o=1 next cycle.
REQ-037 Issue id 5, commit kill=1, exec id 5 -> no result_valid_o, occupancy returns to 0.
REQ-038 Result pending, result_ready_i=0 for 5 cycles -> result_o constant; exec_exc_i=1 case gives we=0, exccode propagated.
REQ-039 Same-cycle issue+commit+exec id 7 -> result_valid_o=1 next cycle; rst_i pulse while valid -> result_valid_o=0.
